// File: rtl/debounce_pkg.sv
// Shared types and helpers for the push-button debouncer and related input conditioning.
package debounce_pkg;

   typedef enum logic {
      DEB_STABLE = 1'b0,
      DEB_COUNT  = 1'b1
   } deb_state_t;

   // Width of the qualification counter; never narrower than one bit so that
   // DEBOUNCE_CYCLES=1 still yields a legal vector.
   function automatic int counter_width(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/input_synchronizer.sv
// Multi-flop synchroniser for an asynchronous single-bit board input.
// The last stage is the only output; nothing downstream sees the raw pin.
module input_synchronizer #(
   parameter int   STAGES      = 2,
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic synced
);

   logic [STAGES-1:0] chain;

   // Shift the raw level through the flop chain; reset loads the idle level.
   always_ff @(posedge clk) begin
      if (!rst) begin
         chain <= {STAGES{RESET_VALUE}};
      end else begin
         chain <= {chain[STAGES-2:0], level};
      end
   end

   assign synced = chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronises the raw active-low pin and lets btn_out
// follow it only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 1_000_000,
   parameter int   SYNC_STAGES     = 2,
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_out,
   output logic busy
);

   localparam int             CNT_W = counter_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             btn_sync;
   deb_state_t       state;
   deb_state_t       state_next;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] counter_next;
   logic             out_next;

   input_synchronizer #(
      .STAGES      (SYNC_STAGES),
      .RESET_VALUE (IDLE_LEVEL)
   ) u_sync (
      .clk    (clk),
      .rst    (rst),
      .level  (btn_raw),
      .synced (btn_sync)
   );

   // State, counter and debounced level registers; reset discards any pending transition.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= DEB_STABLE;
         counter <= '0;
         btn_out <= IDLE_LEVEL;
      end else begin
         state   <= state_next;
         counter <= counter_next;
         btn_out <= out_next;
      end
   end

   // Next-state logic: a mismatch must persist DEBOUNCE_CYCLES cycles in DEB_COUNT;
   // any return to the current level restarts from zero. Counter clears before it can wrap.
   always_comb begin
      state_next   = state;
      counter_next = '0;
      out_next     = btn_out;
      case (state)
         DEB_STABLE: begin
            if (btn_sync != btn_out) begin
               state_next = DEB_COUNT;
            end
         end
         DEB_COUNT: begin
            if (btn_sync == btn_out) begin
               state_next = DEB_STABLE;
            end else if (counter == LAST) begin
               out_next   = btn_sync;
               state_next = DEB_STABLE;
            end else begin
               counter_next = counter + 1'b1;
            end
         end
         default: begin
            state_next = DEB_STABLE;
         end
      endcase
   end

   assign busy = (state == DEB_COUNT);

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with N=4, S=2: stimulus pushes the expected
// busy/btn_out change events, an independent monitor pops them as the DUT changes.
module tb_button_debouncer;

   localparam int N = 4;
   localparam int S = 2;

   logic clk;
   logic rst;
   logic btn_raw;
   logic btn_out;
   logic busy;

   button_debouncer #(
      .DEBOUNCE_CYCLES (N),
      .SYNC_STAGES     (S),
      .IDLE_LEVEL      (1'b1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_raw),
      .btn_out (btn_out),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      bit sig;   // 0 = busy, 1 = btn_out
      bit val;
   } ev_t;

   ev_t exp_q[$];
   int  tests = 0;
   int  fails = 0;
   bit  mon_en = 1'b0;
   logic prev_busy;
   logic prev_out;

   task automatic push_ev(input int c, input bit s, input bit v);
      ev_t e;
      e.cyc = c;
      e.sig = s;
      e.val = v;
      exp_q.push_back(e);
   endtask

   // btn_raw has just settled (held from the next edge k) at a level different from btn_out.
   task automatic push_trans(input bit v);
      int k;
      k = cyc + 1;
      push_ev(k + S,     1'b0, 1'b1);
      push_ev(k + S + N, 1'b0, 1'b0);
      push_ev(k + S + N, 1'b1, v);
   endtask

   task automatic check_ev(input bit s, input bit v);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_change sig=%0s got val=%0b at cycle %0d, expected no change",
                  s ? "btn_out" : "busy", v, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.cyc != cyc || e.sig != s || e.val != v) begin
            fails++;
            $display("FAIL event got sig=%0s val=%0b cycle=%0d, expected sig=%0s val=%0b cycle=%0d",
                     s ? "btn_out" : "busy", v, cyc, e.sig ? "btn_out" : "busy", e.val, e.cyc);
         end
      end
   endtask

   // Monitor: any change on busy or btn_out must match the head of the expected queue.
   always @(negedge clk) begin
      if (mon_en) begin
         if (busy !== prev_busy) begin
            check_ev(1'b0, busy);
            prev_busy = busy;
         end
         if (btn_out !== prev_out) begin
            check_ev(1'b1, btn_out);
            prev_out = btn_out;
         end
      end
   end

   task automatic check_bit(input string name, input logic act, input logic req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %0s got %0b, expected %0b (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_drained(input string name);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %0s %0d expected events never seen, next at cycle %0d",
                  name, exp_q.size(), exp_q[0].cyc);
         exp_q.delete();
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic monitor_on();
      prev_busy = busy;
      prev_out  = btn_out;
      mon_en    = 1'b1;
   endtask

   initial begin
      int k;
      rst     = 1'b0;
      btn_raw = 1'b0;

      // 1. reset with the button held pressed
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_bit("reset_btn_out", btn_out, 1'b1);
         check_bit("reset_busy", busy, 1'b0);
      end
      rst = 1'b1;
      monitor_on();
      push_trans(1'b0);
      step(12);
      check_drained("reset_release");

      // 2. clean release, press, release
      btn_raw = 1'b1;
      push_trans(1'b1);
      step(20);
      btn_raw = 1'b0;
      push_trans(1'b0);
      step(20);
      btn_raw = 1'b1;
      push_trans(1'b1);
      step(20);
      check_drained("clean_press_release");

      // 3a. three-cycle glitch rejected
      k = cyc + 1;
      btn_raw = 1'b0;
      push_ev(k + 2, 1'b0, 1'b1);
      push_ev(k + 5, 1'b0, 1'b0);
      step(3);
      btn_raw = 1'b1;
      step(12);
      check_drained("glitch_3");
      check_bit("glitch_counter_zero", dut.counter == 0, 1'b1);

      // 3b. N-cycle pulse is the longest that is still rejected
      k = cyc + 1;
      btn_raw = 1'b0;
      push_ev(k + 2, 1'b0, 1'b1);
      push_ev(k + 6, 1'b0, 1'b0);
      step(4);
      btn_raw = 1'b1;
      step(12);
      check_drained("glitch_N");

      // 3c. N+1-cycle pulse propagates, then the release qualifies too
      k = cyc + 1;
      btn_raw = 1'b0;
      push_ev(k + 2,  1'b0, 1'b1);
      push_ev(k + 6,  1'b0, 1'b0);
      push_ev(k + 6,  1'b1, 1'b0);
      push_ev(k + 7,  1'b0, 1'b1);
      push_ev(k + 11, 1'b0, 1'b0);
      push_ev(k + 11, 1'b1, 1'b1);
      step(5);
      btn_raw = 1'b1;
      step(14);
      check_drained("pulse_N_plus_1");

      // 4. bounce burst: single-cycle lows, then settle low
      k = cyc + 1;
      for (int i = 0; i < 10; i += 2) begin
         push_ev(k + i + 2, 1'b0, 1'b1);
         push_ev(k + i + 3, 1'b0, 1'b0);
      end
      push_ev(k + 12, 1'b0, 1'b1);
      push_ev(k + 16, 1'b0, 1'b0);
      push_ev(k + 16, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         btn_raw = (i % 2 == 1);
         step(1);
      end
      btn_raw = 1'b0;
      step(15);
      check_drained("bounce_burst");
      btn_raw = 1'b1;
      push_trans(1'b1);
      step(12);
      check_drained("bounce_release");

      // 5. reset while qualifying a press
      k = cyc + 1;
      btn_raw = 1'b0;
      push_ev(k + 2, 1'b0, 1'b1);
      step(5);
      check_bit("midcount_busy", busy, 1'b1);
      check_bit("midcount_counter_two", dut.counter == 2, 1'b1);
      check_drained("midcount_pre_reset");
      mon_en = 1'b0;
      rst = 1'b0;
      step(1);
      check_bit("midcount_reset_btn_out", btn_out, 1'b1);
      check_bit("midcount_reset_busy", busy, 1'b0);
      check_bit("midcount_reset_counter_zero", dut.counter == 0, 1'b1);
      rst = 1'b1;
      monitor_on();
      push_trans(1'b0);
      step(12);
      check_drained("midcount_requalify");
      btn_raw = 1'b1;
      push_trans(1'b1);
      step(12);
      check_drained("midcount_release");

      // 6. long hold
      btn_raw = 1'b0;
      push_trans(1'b0);
      step(200);
      check_drained("long_hold");
      check_bit("long_hold_btn_out", btn_out, 1'b0);
      check_bit("long_hold_busy", busy, 1'b0);

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions the raw, asynchronous, active-low push-button pin before it reaches edge_detector.
- Synchronises the pin into the clk domain and suppresses contact bounce and glitches with a counter-qualified two-state FSM.
- Drives a clean, glitch-free level on btn_out, which feeds edge_detector.signal_in directly.
- Idle level is high, so one physical press produces exactly one falling edge downstream.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before btn_out follows the input (20 ms at 50 MHz). Legal range >= 1; benches override it to 4.
- SYNC_STAGES, 2, number of synchroniser flops. Legal range >= 2.
- IDLE_LEVEL, 1'b1, reset value of the synchroniser flops and of btn_out.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-low reset (rst=0 resets on next rising clk edge)
- btn_raw  input  1  raw, asynchronous button pin, active-low
- btn_out  output  1  debounced level, feeds edge_detector.signal_in
- busy  output  1  high while a candidate transition is being qualified

Behaviour:
- Reset (rst=0 at a rising edge):
  - all synchroniser flops <= IDLE_LEVEL
  - btn_out <= IDLE_LEVEL
  - state <= DEB_STABLE; busy=0
  - counter <= 0
  - Reset has priority over every other event.
- Synchroniser:
  - SYNC_STAGES-deep flop chain.
  - btn_raw is never used combinationally or sampled anywhere else.
  - Its last stage is called btn_sync.
- Counter:
  - width = max(1, $clog2(DEBOUNCE_CYCLES)), unsigned.
  - Never wraps: it is compared against DEBOUNCE_CYCLES-1 and cleared before overflow.
- FSM, DEB_STABLE:
  - btn_sync == btn_out: hold, counter=0.
  - btn_sync != btn_out: go to DEB_COUNT, counter <= 0.
- FSM, DEB_COUNT:
  - btn_sync == btn_out (glitch): go to DEB_STABLE, counter <= 0, btn_out unchanged.
  - Mismatch and counter == DEBOUNCE_CYCLES-1: btn_out <= btn_sync, go to DEB_STABLE, counter <= 0.
  - Otherwise: counter <= counter + 1.
- busy = (state == DEB_COUNT). It is a registered-state decode, with no combinational path from btn_raw.
- Latency:
  - btn_raw changes before rising edge k and then holds.
  - btn_out takes the new value at edge k + SYNC_STAGES + DEBOUNCE_CYCLES, i.e. after S+N+1 edges. That is 7 edges for S=2, N=4.
  - busy rises at edge k+S and falls together with the btn_out update.
- Glitch rule: any return to the current btn_out level during DEB_COUNT restarts qualification from zero. A pulse of up to N synchronised cycles is never propagated.
- btn_out changes at most once per qualification window and is glitch-free (registered).
- Reset mid-count discards the pending transition. If btn_raw differs from IDLE_LEVEL after reset release, a full qualification follows before btn_out changes.
- DEBOUNCE_CYCLES=1 is legal: btn_out follows btn_sync after a single DEB_COUNT cycle.

Decomposition:
- Package debounce_pkg:
  - typedef enum logic {DEB_STABLE, DEB_COUNT} deb_state_t
  - localparam function for counter width
- Sub-module input_synchronizer:
  - parameterised on STAGES and RESET_VALUE, same clk/rst ports.
  - Reused later for other asynchronous board inputs (switches, UART rx).
- FSM and counter stay in button_debouncer.

Test Plan:
All scenarios use N=4, S=2, clk period 20 ns, IDLE_LEVEL=1.
1. Reset:
   - Stimulus: btn_raw=0 held, rst=0 for 3 edges, then rst=1.
   - Response: during reset btn_out=1, busy=0. After release busy=1 from edge 2, btn_out=0 at edge 7, busy=0 thereafter.
2. Clean press/release:
   - Stimulus: btn_raw 1->0 held 20 cycles, then 0->1.
   - Response: btn_out falls exactly 7 edges after each change, busy high for exactly 5 edges per transition, single btn_out transition each way.
3. Short glitch:
   - Stimulus: btn_raw=0 for 3 cycles, then back to 1.
   - Response: btn_out stays 1 throughout, busy pulses then returns to 0, counter back to 0.
4. Bounce burst:
   - Stimulus: btn_raw toggles every cycle for 10 cycles, then settles at 0.
   - Response: btn_out shows exactly one 1->0 transition, 7 edges after the final settle. With edge_detector attached, edge_detected pulses exactly once.
5. Reset mid-count:
   - Stimulus: press, then rst=0 while busy=1, counter=2.
   - Response: next edge btn_out=1, busy=0, counter=0. After release with btn_raw still 0, a full 7-edge qualification precedes btn_out=0.
6. Long hold:
   - Stimulus: btn_raw=0 held 200 cycles.
   - Response: btn_out=0 from edge 7 onward with no further transitions, busy=0 after qualification.
